iq_sat_addsub: RTL and testbench
================================

// Module: iq_sat_addsub
// PURPOSE
//  Multi-channel, pipelined, saturating add/subtract unit for DRFM I/Q sample streams.
//  Generalises the single-pair 32-bit subtractor: parametrised width and channel count, and run-time add/sub mode.
//  Adds valid/ready backpressure, per-channel overflow flags, and sticky overflow status.
//  Sits between the mixer/DDS outputs and the downstream filter/packer stages.
// PARAMETERS
//  DATA_W    32  input sample width per channel (2's comp)
//  OUT_W     32  output width per channel; result saturated to this width; 2 <= OUT_W <= DATA_W+1
//  CHANNELS  2   number of independent lanes, lane k = bits [k*W +: W]
//  CNT_W     16  width of overflow event counter (OVF_COUNT_EN only)
// PORTS
//  M100CLK     in   1                 system clock, all logic on rising edge
//  reset       in   1                 asynchronous, active-high reset
//  mode        in   1                 0 = a-b (MODE_SUB), 1 = a+b (MODE_ADD); sampled with data
//  in_valid    in   1                 input beat valid
//  in_ready    out  1                 unit accepts a beat this cycle
//  a           in   CHANNELS*DATA_W   operand A lanes
//  b           in   CHANNELS*DATA_W   operand B lanes
//  out_valid   out  1                 result beat valid
//  out_ready   in   1                 downstream accepts result
//  result      out  CHANNELS*OUT_W    saturated results
//  ovf         out  CHANNELS          per-lane "this beat saturated", aligned with result
//  sticky_ovf  out  CHANNELS          per-lane latched overflow since last clear
//  clr_sticky  in   1                 single-cycle pulse, clears sticky_ovf
//  ovf_count   out  CNT_W             overflow beat count (OVF_COUNT_EN only)
// BEHAVIOUR
//  - Reset (async): all valid bits, result, ovf, sticky_ovf, ovf_count = 0; in_ready = 1 after release.
//  - Two register stages: S1 = full-precision sum, S2 = saturated output regs.
//  - Pipeline enable: en = !out_valid | out_ready; in_ready = en. All stages advance together on en.
//  - Transfers: input on in_valid&in_ready, output on out_valid&out_ready.
//  - Latency: 2 cycles accept-to-out_valid with out_ready held high; throughput 1 beat/cycle.
//  - When en = 0, every register holds its value: data, valid bits and the mode captured in S1.
//  - S1: full = sext(a,DATA_W+1) +/- sext(b,DATA_W+1). Subtract is computed as a + ~b + 1 in DATA_W+1 bits; never wraps.
//  - S2: full > 2^(OUT_W-1)-1 -> max positive, ovf=1; full < -2^(OUT_W-1) -> max negative, ovf=1; otherwise full[OUT_W-1:0], ovf=0.
//  - With OUT_W = DATA_W+1, ovf is constant 0.
//  - Bubbles: S1 valid=0 passes to S2. A bubble never sets sticky/ovf and never increments the counter.
//  - sticky_ovf[k] sets on S2 load (en & S1 valid) with lane overflow.
//  - clr_sticky clears sticky_ovf; a set in the same cycle wins (bit stays 1).
//  - reset mid-stream: in-flight beats are discarded; no partial output.
// CONFIGURATION
//  - `define OVF_COUNT_EN: ovf_count increments by 1 per beat loaded into S2 with any lane overflow.
//    It saturates at 2^CNT_W-1, clears on reset and on clr_sticky; increment wins over clear.
//  - Without OVF_COUNT_EN: ovf_count port is absent and no counter logic is built.
// STRUCTURE
//  - Package iq_arith_pkg: MODE_SUB/MODE_ADD constants; sat_max(w)/sat_min(w) functions.
//  - Sub-module iq_sat_clip: one lane, combinational (DATA_W+1)->OUT_W clip plus ovf bit.
//    Instantiated CHANNELS times via generate; pipeline, handshake and status live in the top.
// TESTING (DATA_W=32, OUT_W=32, CHANNELS=2)
//  1. SUB, a={5,-3}, b={7,-3}, out_ready=1 -> after 2 clk result={-2,0}, ovf=00.
//  2. SUB, a=0, b=0x80000000 -> 0x7FFFFFFF, ovf=1, sticky=1; ADD, a=b=0x80000000 -> 0x80000000, ovf=1.
//  3. Stream 8 beats with out_ready toggling 1,0,0,1 -> all 8 results in order, none lost/duplicated;
//     in_ready = 0 while out_valid & !out_ready.
//  4. Overflow on lane 0 and clr_sticky in same cycle -> sticky_ovf[0]=1; clr next cycle alone -> 0.
//  5. Assert reset with 2 beats in flight -> out_valid=0 immediately (async); after release first new beat has 2-clk latency.
//  6. OVF_COUNT_EN, CNT_W=2: 5 overflow beats -> ovf_count sequence 1,2,3,3,3; clr_sticky -> 0.

Source files
------------

// File: rtl/iq_arith_pkg.sv
// iq_arith_pkg: add/sub mode encodings and saturation bounds for the I/Q arithmetic unit.
// The sat_* helpers return the w-bit two's-complement bound in the low bits of a wide vector.
package iq_arith_pkg;
    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;
    localparam int SAT_W = 128;

    function automatic logic [SAT_W-1:0] sat_max(input int w);
        return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    endfunction

    function automatic logic [SAT_W-1:0] sat_min(input int w);
        return SAT_W'(1) << (w - 1);
    endfunction
endpackage

// File: rtl/iq_sat_clip.sv
// iq_sat_clip: one-lane combinational clip of a (DATA_W+1)-bit sum to OUT_W bits with overflow flag.
module iq_sat_clip
    import iq_arith_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 32
)(
    input  logic [DATA_W:0]  full,
    output logic [OUT_W-1:0] result,
    output logic             ovf
);
    localparam int TW = DATA_W + 2 - OUT_W;
    localparam logic [OUT_W-1:0] MAX_V = OUT_W'(sat_max(OUT_W));
    localparam logic [OUT_W-1:0] MIN_V = OUT_W'(sat_min(OUT_W));

    logic [TW-1:0] top_bits;

    // the value fits iff every bit from the sum's MSB down to the output sign bit agrees
    always_comb begin
        top_bits = full[DATA_W -: TW];
        ovf = |top_bits & ~&top_bits;
        result = ovf ? (full[DATA_W] ? MIN_V : MAX_V) : full[OUT_W-1:0];
    end
endmodule

// File: rtl/iq_sat_addsub.sv
// iq_sat_addsub: multi-lane two-stage saturating add/sub with valid/ready and sticky overflow.
// Optional overflow beat counter enabled by `define OVF_COUNT_EN.
module iq_sat_addsub
    import iq_arith_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int OUT_W    = 32,
    parameter int CHANNELS = 2
`ifdef OVF_COUNT_EN
    , parameter int CNT_W  = 16
`endif
)(
    input  logic                         M100CLK,
    input  logic                         reset,
    input  logic                         mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   a,
    input  logic [CHANNELS*DATA_W-1:0]   b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*OUT_W-1:0]    result,
    output logic [CHANNELS-1:0]          ovf,
    output logic [CHANNELS-1:0]          sticky_ovf,
`ifdef OVF_COUNT_EN
    output logic [CNT_W-1:0]             ovf_count,
`endif
    input  logic                         clr_sticky
);
    localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

    logic                                en;
    logic                                load;
    logic                                s1_valid;
    logic [CHANNELS-1:0][DATA_W:0]       full_d;
    logic [CHANNELS-1:0][DATA_W:0]       s1_full;
    logic [CHANNELS-1:0][OUT_W-1:0]      clip_res;
    logic [CHANNELS-1:0]                 clip_ovf;

    assign en       = !out_valid | out_ready;
    assign in_ready = en;
    assign load     = en & s1_valid;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic [DATA_W:0] ae;
        logic [DATA_W:0] be;
        assign ae = {a[k*DATA_W+DATA_W-1], a[k*DATA_W +: DATA_W]};
        assign be = {b[k*DATA_W+DATA_W-1], b[k*DATA_W +: DATA_W]};
        assign full_d[k] = (mode == MODE_ADD) ? ae + be : ae + ~be + ONE;
        iq_sat_clip #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_clip (
            .full   (s1_full[k]),
            .result (clip_res[k]),
            .ovf    (clip_ovf[k])
        );
    end

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_full    <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            ovf        <= '0;
            sticky_ovf <= '0;
        end else begin
            if (en) begin
                s1_valid  <= in_valid;
                s1_full   <= full_d;
                out_valid <= s1_valid;
                result    <= clip_res;
                ovf       <= s1_valid ? clip_ovf : '0;
            end
            // a new overflow survives a simultaneous clear
            sticky_ovf <= (clr_sticky ? '0 : sticky_ovf) | (load ? clip_ovf : '0);
        end
    end

`ifdef OVF_COUNT_EN
    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset)
            ovf_count <= '0;
        else if (load & |clip_ovf)
            ovf_count <= (ovf_count == '1) ? ovf_count : ovf_count + CNT_W'(1);
        else if (clr_sticky)
            ovf_count <= '0;
    end
`endif
endmodule

// File: tb/tb_iq_sat_addsub.sv
// tb_iq_sat_addsub: directed self-checking bench for iq_sat_addsub (DATA_W=OUT_W=32, CHANNELS=2).
module tb_iq_sat_addsub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr_sticky = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] result;
    logic [1:0]  ovf;
    logic [1:0]  sticky_ovf;
`ifdef OVF_COUNT_EN
    logic [1:0]  ovf_count;
`endif
    int passed = 0;
    int total = 0;

    iq_sat_addsub #(.DATA_W(32), .OUT_W(32), .CHANNELS(2)
`ifdef OVF_COUNT_EN
        , .CNT_W(2)
`endif
    ) dut (
        .M100CLK    (clk),
        .reset      (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .ovf        (ovf),
        .sticky_ovf (sticky_ovf),
`ifdef OVF_COUNT_EN
        .ovf_count  (ovf_count),
`endif
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (result !== 64'h0) $display("FAIL reset_result got %h want 0", result); else passed++;
        total++; if (ovf !== 2'b00) $display("FAIL reset_ovf got %b want 00", ovf); else passed++;
        total++; if (sticky_ovf !== 2'b00) $display("FAIL reset_sticky got %b want 00", sticky_ovf); else passed++;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        tick();
    endtask

    task automatic test_sub();
        mode = 1'b0;
        a = {32'hFFFF_FFFD, 32'd5};
        b = {32'hFFFF_FFFD, 32'd7};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL sub_latency1 got %b want 0", out_valid); else passed++;
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL sub_latency2 got %b want 1", out_valid); else passed++;
        total++; if (result !== {32'h0, 32'hFFFF_FFFE}) $display("FAIL sub_result got %h want %h", result, {32'h0, 32'hFFFF_FFFE}); else passed++;
        total++; if (ovf !== 2'b00) $display("FAIL sub_ovf got %b want 00", ovf); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL sub_bubble got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_saturate();
        mode = 1'b0;
        a = {32'd1, 32'd0};
        b = {32'd1, 32'h8000_0000};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (result !== {32'h0, 32'h7FFF_FFFF}) $display("FAIL sat_pos_result got %h want %h", result, {32'h0, 32'h7FFF_FFFF}); else passed++;
        total++; if (ovf !== 2'b01) $display("FAIL sat_pos_ovf got %b want 01", ovf); else passed++;
        total++; if (sticky_ovf !== 2'b01) $display("FAIL sat_pos_sticky got %b want 01", sticky_ovf); else passed++;
        mode = 1'b1;
        a = {32'h8000_0000, 32'd0};
        b = {32'h8000_0000, 32'd0};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (result !== {32'h8000_0000, 32'h0}) $display("FAIL sat_neg_result got %h want %h", result, {32'h8000_0000, 32'h0}); else passed++;
        total++; if (ovf !== 2'b10) $display("FAIL sat_neg_ovf got %b want 10", ovf); else passed++;
        total++; if (sticky_ovf !== 2'b11) $display("FAIL sat_neg_sticky got %b want 11", sticky_ovf); else passed++;
        tick();
        total++; if (ovf !== 2'b00) $display("FAIL bubble_ovf got %b want 00", ovf); else passed++;
        total++; if (sticky_ovf !== 2'b11) $display("FAIL bubble_sticky got %b want 11", sticky_ovf); else passed++;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        total++; if (sticky_ovf !== 2'b00) $display("FAIL sticky_clear got %b want 00", sticky_ovf); else passed++;
    endtask

    task automatic test_clr_collision();
        mode = 1'b0;
        a = 64'h0;
        b = {32'd0, 32'h8000_0000};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        clr_sticky = 1'b1;
        tick();
        total++; if (sticky_ovf !== 2'b01) $display("FAIL clr_collision_sticky got %b want 01", sticky_ovf); else passed++;
        total++; if (ovf !== 2'b01) $display("FAIL clr_collision_ovf got %b want 01", ovf); else passed++;
        tick();
        clr_sticky = 1'b0;
        total++; if (sticky_ovf !== 2'b00) $display("FAIL clr_alone_sticky got %b want 00", sticky_ovf); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  pat = 4'b1001;
        logic [63:0] q[$];
        logic        mv1 = 1'b0;
        logic        mv2 = 1'b0;
        logic        exp_rdy;
        int          sent = 0;
        int          got = 0;
        mode = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            out_ready = pat[c % 4];
            in_valid = (sent < 8);
            a = {32'(-sent), 32'(sent * 3 + 1)};
            b = {32'd100, 32'(sent * 5)};
            #1;
            exp_rdy = !mv2 | out_ready;
            total++; if (in_ready !== exp_rdy) $display("FAIL stream_in_ready c=%0d got %b want %b", c, in_ready, exp_rdy); else passed++;
            total++; if (out_valid !== mv2) $display("FAIL stream_out_valid c=%0d got %b want %b", c, out_valid, mv2); else passed++;
            if (mv2 && out_ready) begin
                total++;
                if (q.size() == 0) $display("FAIL stream_result c=%0d got %h want none", c, result);
                else if (result !== q[0]) $display("FAIL stream_result c=%0d got %h want %h", c, result, q[0]);
                else passed++;
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            if (in_valid && exp_rdy) begin
                q.push_back({32'(100 - sent), 32'(sent * 8 + 1)});
                sent++;
            end
            if (exp_rdy) begin
                mv2 = mv1;
                mv1 = in_valid;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++; if (got !== 8) $display("FAIL stream_count got %0d want 8", got); else passed++;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL stream_drain got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_reset_midstream();
        mode = 1'b0;
        out_ready = 1'b1;
        a = {32'd0, 32'd10};
        b = {32'd0, 32'd3};
        in_valid = 1'b1;
        tick();
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", out_valid); else passed++;
        #1;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_async_valid got %b want 0", out_valid); else passed++;
        total++; if (result !== 64'h0) $display("FAIL mid_async_result got %h want 0", result); else passed++;
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL mid_discard1 got %b want 0", out_valid); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL mid_discard2 got %b want 0", out_valid); else passed++;
        a = {32'd0, 32'd20};
        b = {32'd0, 32'd1};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_new_lat1 got %b want 0", out_valid); else passed++;
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL mid_new_lat2 got %b want 1", out_valid); else passed++;
        total++; if (result !== {32'd0, 32'd19}) $display("FAIL mid_new_result got %h want %h", result, {32'd0, 32'd19}); else passed++;
        tick();
    endtask

`ifdef OVF_COUNT_EN
    task automatic test_ovf_count();
        logic [1:0] exp_cnt;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        total++; if (ovf_count !== 2'd0) $display("FAIL cnt_clear0 got %0d want 0", ovf_count); else passed++;
        mode = 1'b0;
        out_ready = 1'b1;
        a = 64'h0;
        b = {32'd0, 32'h8000_0000};
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 5);
            tick();
            if (c >= 1) begin
                exp_cnt = (c > 3) ? 2'd3 : 2'(c);
                total++; if (ovf_count !== exp_cnt) $display("FAIL cnt_seq c=%0d got %0d want %0d", c, ovf_count, exp_cnt); else passed++;
            end
        end
        in_valid = 1'b0;
        tick();
        total++; if (ovf_count !== 2'd3) $display("FAIL cnt_hold got %0d want 3", ovf_count); else passed++;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        total++; if (ovf_count !== 2'd0) $display("FAIL cnt_clear got %0d want 0", ovf_count); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_sub();
        test_saturate();
        test_clr_collision();
        test_back_to_back();
        test_reset_midstream();
`ifdef OVF_COUNT_EN
        test_ovf_count();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
